pueo_turfhdr_framer: RTL and testbench
======================================

PUEO_TURFHDR_FRAMER -- requirements
Module: pueo_turfhdr_framer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, header buffer depth in entries (power of 2, 2..16).
REQ-002 SHALL have parameter SYSCLKTYPE, default "NONE", clock-type annotation.
REQ-003 SHALL have port sysclk_i  input  1  system clock; the only clock.
REQ-004 SHALL have port sysclk_rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port runrst_i  input  1  run reset pulse (clears event number and timestamp).
REQ-006 SHALL have port s_hdr_tdata  input  64  trigger header word from master trigger process.
REQ-007 SHALL have port s_hdr_tvalid  input  1  header valid.
REQ-008 SHALL have port s_hdr_tready  output  1  header accept.
REQ-009 SHALL have port m_evt_tdata  output  64  framed event header beat.
REQ-010 SHALL have port m_evt_tvalid  output  1  beat valid.
REQ-011 SHALL have port m_evt_tlast  output  1  last beat of frame.
REQ-012 SHALL have port m_evt_tready  input  1  downstream accept.
REQ-013 SHALL have port stall_count_o  output  16  saturating count of cycles with s_hdr_tvalid high and s_hdr_tready low.

Function
REQ-014 SHALL keep a free-running 48-bit timestamp, incrementing every cycle, wrapping 2^48-1 -> 0.
REQ-015 SHALL, on input handshake, write {s_hdr_tdata, timestamp} into the FIFO; timestamp captured is the value in that same cycle.
REQ-016 SHALL drive s_hdr_tready = FIFO not full; never drop a header.
REQ-017 SHALL run states IDLE, BEAT0, BEAT1, BEAT2: IDLE->BEAT0 when FIFO non-empty; BEATn->BEATn+1 on output handshake; BEAT2->BEAT0 on handshake if FIFO non-empty, else IDLE.
REQ-018 SHALL emit BEAT0 = {16'h5045, 16'h0000, evnum[31:0]}.
REQ-019 SHALL emit BEAT1 = stored header word unchanged.
REQ-020 SHALL emit BEAT2 = {16'h0000, stored timestamp[47:0]} with m_evt_tlast=1; tlast 0 on other beats.
REQ-021 SHALL pop the FIFO on the BEAT2 handshake only.
REQ-022 SHALL assign evnum on IDLE/BEAT2->BEAT0 transition, then increment the 32-bit counter (wraps).
REQ-023 SHALL hold m_evt_tdata/tlast stable while m_evt_tvalid && !m_evt_tready; m_evt_tvalid high exactly in BEAT0..BEAT2.
REQ-024 SHALL give latency: header accepted cycle N -> BEAT0 valid at cycle N+2 earliest (FIFO empty, IDLE).
REQ-025 SHALL sustain one frame per 3 cycles with m_evt_tready held high.
REQ-026 SHALL on runrst_i zero timestamp and evnum counter next cycle; FIFO contents and frame in flight SHALL be untouched.
REQ-027 SHALL on runrst_i coincident with a BEAT0 transition give that frame evnum 0 and leave counter at 1.
REQ-028 SHALL on runrst_i coincident with an input handshake capture timestamp 0.
REQ-029 SHALL allow simultaneous FIFO push and pop when full (pop frees slot; s_hdr_tready still reflects pre-pop full).
REQ-030 SHALL saturate stall_count_o at 16'hFFFF; cleared only by sysclk_rst_i or runrst_i.

Reset
REQ-031 SHALL on sysclk_rst_i: state IDLE, FIFO empty, timestamp 0, evnum 0, stall_count_o 0, m_evt_tvalid 0, m_evt_tlast 0, m_evt_tdata 0, s_hdr_tready 0 during reset then 1.
REQ-032 SHALL on reset mid-frame abandon the frame; no partial frame resumes.

Structure
REQ-033 SHALL place magic 16'h5045, beat count 3, state enum, timestamp/evnum widths in package pueo_turfhdr_pkg.
REQ-034 SHALL implement buffer as sub-module pueo_turfhdr_fifo (112-bit wide, FIFO_DEPTH, sync, full/empty flags).

Verification
REQ-035 SHALL test single header 64'h1234 at timestamp 100, tready=1 -> beats {5045_0000_00000000}, {1234}, {0000_000000000064} tlast; valid from N+2.
REQ-036 SHALL test 6 back-to-back headers, tready=0 for 50 cycles -> s_hdr_tready low after 4 accepted, stall_count_o increments, all 6 frames emitted in order, evnum 0..5.
REQ-037 SHALL test random tready toggling over 1000 frames -> tdata stable under stall, exactly one tlast per 3 beats, no loss.
REQ-038 SHALL test runrst_i during BEAT1 of evnum 7 -> that frame completes unchanged, next frame evnum 0, timestamps restart near 0.
REQ-039 SHALL test preload timestamp 2^48-2, accept headers on consecutive cycles -> captured 2^48-2, 2^48-1, 0.
REQ-040 SHALL test sysclk_rst_i asserted in BEAT0 -> m_evt_tvalid 0 next cycle, FIFO empty, evnum restarts at 0.

Source files
------------

// File: rtl/pueo_turfhdr_pkg.sv
// Shared constants and types for the TURF trigger-header framer.
package pueo_turfhdr_pkg;

    localparam int unsigned TS_W        = 48;
    localparam int unsigned EVNUM_W     = 32;
    localparam int unsigned HDR_W       = 64;
    localparam int unsigned ENTRY_W     = HDR_W + TS_W;
    localparam logic [15:0] FRAME_MAGIC = 16'h5045;
    localparam int unsigned FRAME_BEATS = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        BEAT2 = 2'd3
    } framer_state_t;

    // Beat states are numbered from 1, so the last beat's code equals the beat count.
    localparam framer_state_t ST_LAST = framer_state_t'(FRAME_BEATS[1:0]);

endpackage

// File: rtl/pueo_turfhdr_fifo.sv
// Synchronous show-ahead FIFO holding {header, timestamp} entries.
module pueo_turfhdr_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 112
) (
    input  logic                       sysclk_i,
    input  logic                       sysclk_rst_i,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           din,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr_q, rptr_q;
    logic             do_wr, do_rd;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign level = wptr_q - rptr_q;
    assign do_rd = rd_en & ~empty;
    assign do_wr = wr_en & (~full | do_rd);
    assign dout  = mem[rptr_q[AW-1:0]];

    always_ff @(posedge sysclk_i) begin
        if (sysclk_rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_wr) wptr_q <= wptr_q + 1'b1;
            if (do_rd) rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge sysclk_i) begin
        if (do_wr) mem[wptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/pueo_turfhdr_framer.sv
// Frames each trigger header as three beats: magic+event number, header, timestamp.
module pueo_turfhdr_framer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter string       SYSCLKTYPE = "NONE"
) (
    input  logic        sysclk_i,
    input  logic        sysclk_rst_i,
    input  logic        runrst_i,
    input  logic [63:0] s_hdr_tdata,
    input  logic        s_hdr_tvalid,
    output logic        s_hdr_tready,
    output logic [63:0] m_evt_tdata,
    output logic        m_evt_tvalid,
    output logic        m_evt_tlast,
    input  logic        m_evt_tready,
    output logic [15:0] stall_count_o
);

    import pueo_turfhdr_pkg::*;

    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    // Clock-type annotation only; no logic depends on it.
    if (SYSCLKTYPE == "NONE") begin : g_sysclk_plain
    end

    framer_state_t      state_q, state_d;
    logic [TS_W-1:0]    ts_q, ts_capture;
    logic [EVNUM_W-1:0] evcnt_q, evnum_q;
    logic [15:0]        stall_q;
    logic [ENTRY_W-1:0] fifo_dout;
    logic [LVL_W-1:0]   fifo_level;
    logic               fifo_full, fifo_empty;
    logic               push, pop, more, start_frame;

    assign s_hdr_tready  = ~fifo_full & ~sysclk_rst_i;
    assign push          = s_hdr_tvalid & s_hdr_tready;
    assign ts_capture    = runrst_i ? '0 : ts_q;
    assign pop           = (state_q == ST_LAST) & m_evt_tready;
    // A header pushed during the final beat lets the next frame start without a bubble.
    assign more          = (fifo_level > LVL_W'(1)) | push;
    assign start_frame   = ((state_q == IDLE) & ~fifo_empty) | (pop & more);
    assign stall_count_o = stall_q;

    pueo_turfhdr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .sysclk_i     (sysclk_i),
        .sysclk_rst_i (sysclk_rst_i),
        .wr_en        (push),
        .din          ({s_hdr_tdata, ts_capture}),
        .rd_en        (pop),
        .dout         (fifo_dout),
        .full         (fifo_full),
        .empty        (fifo_empty),
        .level        (fifo_level)
    );

    always_ff @(posedge sysclk_i) begin
        if (sysclk_rst_i) state_q <= IDLE;
        else              state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty)  state_d = BEAT0;
            BEAT0:   if (m_evt_tready) state_d = BEAT1;
            BEAT1:   if (m_evt_tready) state_d = BEAT2;
            BEAT2:   if (m_evt_tready) state_d = more ? BEAT0 : IDLE;
            default:                   state_d = IDLE;
        endcase
    end

    always_comb begin
        m_evt_tvalid = 1'b0;
        m_evt_tlast  = 1'b0;
        m_evt_tdata  = '0;
        case (state_q)
            BEAT0: begin
                m_evt_tvalid = 1'b1;
                m_evt_tdata  = {FRAME_MAGIC, 16'h0000, evnum_q};
            end
            BEAT1: begin
                m_evt_tvalid = 1'b1;
                m_evt_tdata  = fifo_dout[ENTRY_W-1 -: HDR_W];
            end
            BEAT2: begin
                m_evt_tvalid = 1'b1;
                m_evt_tlast  = 1'b1;
                m_evt_tdata  = {16'h0000, fifo_dout[TS_W-1:0]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge sysclk_i) begin
        if (sysclk_rst_i || runrst_i) ts_q <= '0;
        else                          ts_q <= ts_q + 1'b1;
    end

    // Run reset coincident with a frame start numbers that frame 0 and leaves the counter at 1.
    always_ff @(posedge sysclk_i) begin
        if (sysclk_rst_i) begin
            evcnt_q <= '0;
            evnum_q <= '0;
        end else if (start_frame) begin
            evnum_q <= runrst_i ? '0 : evcnt_q;
            evcnt_q <= runrst_i ? EVNUM_W'(1) : evcnt_q + 1'b1;
        end else if (runrst_i) begin
            evcnt_q <= '0;
        end
    end

    always_ff @(posedge sysclk_i) begin
        if (sysclk_rst_i || runrst_i)                           stall_q <= '0;
        else if (s_hdr_tvalid && !s_hdr_tready && stall_q != '1) stall_q <= stall_q + 1'b1;
    end

endmodule

// File: tb/tb_pueo_turfhdr_framer.sv
// Directed and randomized bench for pueo_turfhdr_framer with a transaction-level reference model.
module tb_pueo_turfhdr_framer;

    logic        sysclk_i     = 1'b0;
    logic        sysclk_rst_i = 1'b1;
    logic        runrst_i     = 1'b0;
    logic [63:0] s_hdr_tdata  = '0;
    logic        s_hdr_tvalid = 1'b0;
    logic        s_hdr_tready;
    logic [63:0] m_evt_tdata;
    logic        m_evt_tvalid;
    logic        m_evt_tlast;
    logic        m_evt_tready = 1'b0;
    logic [15:0] stall_count_o;

    pueo_turfhdr_framer #(
        .FIFO_DEPTH (4),
        .SYSCLKTYPE ("NONE")
    ) dut (
        .sysclk_i      (sysclk_i),
        .sysclk_rst_i  (sysclk_rst_i),
        .runrst_i      (runrst_i),
        .s_hdr_tdata   (s_hdr_tdata),
        .s_hdr_tvalid  (s_hdr_tvalid),
        .s_hdr_tready  (s_hdr_tready),
        .m_evt_tdata   (m_evt_tdata),
        .m_evt_tvalid  (m_evt_tvalid),
        .m_evt_tlast   (m_evt_tlast),
        .m_evt_tready  (m_evt_tready),
        .stall_count_o (stall_count_o)
    );

    always #5 sysclk_i = ~sysclk_i;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: headers queue with their capture time; frames consume them in order.
    typedef struct packed {
        logic [63:0] hdr;
        logic [47:0] ts;
    } entry_t;

    entry_t      exp_q[$];
    logic [47:0] mts       = '0;
    logic [31:0] next_ev   = '0;
    logic [31:0] cur_ev    = '0;
    logic [15:0] mstall    = '0;
    int          beat      = 0;
    bit          in_frame  = 0;
    bit          held      = 0;
    logic [63:0] held_data = '0;
    logic        held_last = 1'b0;
    int          frames_done = 0;

    always @(negedge sysclk_i) begin
        if (sysclk_rst_i) begin
            exp_q.delete();
            mts = '0; next_ev = '0; mstall = '0;
            beat = 0; in_frame = 0; held = 0;
        end else begin
            if (held) begin
                chk("hold_valid", m_evt_tvalid, 1);
                chk("hold_data", m_evt_tdata, held_data);
                chk("hold_last", m_evt_tlast, held_last);
            end
            if (m_evt_tvalid && !in_frame) begin
                if (exp_q.size() == 0) chk("spurious_frame", m_evt_tvalid, 0);
                in_frame = 1;
                cur_ev   = next_ev;
                next_ev  = next_ev + 1;
            end
            if (m_evt_tvalid && m_evt_tready && exp_q.size() != 0) begin
                case (beat)
                    0: begin
                        chk("beat0_data", m_evt_tdata, {16'h5045, 16'h0000, cur_ev});
                        chk("beat0_last", m_evt_tlast, 0);
                    end
                    1: begin
                        chk("beat1_data", m_evt_tdata, exp_q[0].hdr);
                        chk("beat1_last", m_evt_tlast, 0);
                    end
                    default: begin
                        chk("beat2_data", m_evt_tdata, {16'h0000, exp_q[0].ts});
                        chk("beat2_last", m_evt_tlast, 1);
                        void'(exp_q.pop_front());
                        frames_done++;
                        in_frame = 0;
                    end
                endcase
                beat = (beat + 1) % 3;
            end
            held      = m_evt_tvalid && !m_evt_tready;
            held_data = m_evt_tdata;
            held_last = m_evt_tlast;
            if (s_hdr_tvalid && s_hdr_tready) begin
                entry_t e;
                e.hdr = s_hdr_tdata;
                e.ts  = runrst_i ? 48'd0 : mts;
                exp_q.push_back(e);
            end
            if (runrst_i) begin
                mstall  = '0;
                next_ev = '0;
            end else if (s_hdr_tvalid && !s_hdr_tready && mstall != 16'hFFFF) begin
                mstall = mstall + 1'b1;
            end
            mts = runrst_i ? 48'd0 : mts + 1'b1;
        end
    end

    task automatic tick();
        @(posedge sysclk_i);
        #1;
    endtask

    task automatic do_reset();
        s_hdr_tvalid = 1'b0;
        runrst_i     = 1'b0;
        sysclk_rst_i = 1'b1;
        repeat (3) tick();
        sysclk_rst_i = 1'b0;
    endtask

    task automatic send(input logic [63:0] d, output bit ok);
        s_hdr_tdata  = d;
        s_hdr_tvalid = 1'b1;
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge sysclk_i);
            if (s_hdr_tready) ok = 1;
            tick();
            if (ok) break;
        end
        s_hdr_tvalid = 1'b0;
        if (!ok) chk("send_timeout", s_hdr_tready, 1);
    endtask

    task automatic wait_frames(input int target, input string tag);
        for (int i = 0; i < 30000 && frames_done < target; i++) tick();
        if (frames_done < target) chk(tag, frames_done, target);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 100 && !m_evt_tvalid; i++) tick();
        if (!m_evt_tvalid) chk(tag, m_evt_tvalid, 1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int acc;
    int base;
    bit ok;

    initial begin
        repeat (4) tick();
        chk("rst_s_tready", s_hdr_tready, 0);
        chk("rst_m_tvalid", m_evt_tvalid, 0);
        chk("rst_m_tlast", m_evt_tlast, 0);
        chk("rst_m_tdata", m_evt_tdata, 0);
        chk("rst_stall", stall_count_o, 0);
        sysclk_rst_i = 1'b0;
        #1;
        chk("post_rst_s_tready", s_hdr_tready, 1);

        // Single header captured at timestamp 100, first beat two cycles later.
        m_evt_tready = 1'b1;
        for (int i = 0; i < 200 && mts != 48'd100; i++) tick();
        s_hdr_tdata  = 64'h1234;
        s_hdr_tvalid = 1'b1;
        tick();
        s_hdr_tvalid = 1'b0;
        chk("lat_n1_valid", m_evt_tvalid, 0);
        tick();
        chk("lat_n2_valid", m_evt_tvalid, 1);
        chk("single_beat0", m_evt_tdata, 64'h5045_0000_0000_0000);
        tick();
        chk("single_beat1", m_evt_tdata, 64'h0000_0000_0000_1234);
        tick();
        chk("single_beat2", m_evt_tdata, 64'h0000_0000_0000_0064);
        chk("single_tlast", m_evt_tlast, 1);
        tick();
        chk("single_idle", m_evt_tvalid, 0);

        // Six back-to-back headers against a stalled output.
        do_reset();
        m_evt_tready = 1'b0;
        base = frames_done;
        acc  = 0;
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    send(64'hA5A5_0000_0000_0000 | 64'(k), ok);
                    if (ok) acc++;
                end
            end
            begin
                repeat (30) tick();
                chk("full_s_tready", s_hdr_tready, 0);
                chk("full_accepted", acc, 4);
                chk("full_stall_cnt", stall_count_o, mstall);
                chk("full_stall_nonzero", stall_count_o != 16'd0, 1);
                repeat (20) tick();
                m_evt_tready = 1'b1;
            end
        join
        wait_frames(base + 6, "burst_frames_timeout");

        // Run reset while frame 7 sits in its header beat.
        do_reset();
        m_evt_tready = 1'b1;
        base = frames_done;
        for (int k = 0; k < 7; k++) send(64'hB000_0000_0000_0000 | 64'(k), ok);
        wait_frames(base + 7, "pre_runrst_timeout");
        m_evt_tready = 1'b0;
        send(64'hBEEF_0007, ok);
        wait_valid("ev7_valid_timeout");
        chk("ev7_beat0", m_evt_tdata, 64'h5045_0000_0000_0007);
        m_evt_tready = 1'b1;
        tick();
        m_evt_tready = 1'b0;
        chk("ev7_in_beat1", m_evt_tdata, 64'hBEEF_0007);
        runrst_i = 1'b1;
        tick();
        runrst_i = 1'b0;
        chk("runrst_beat1_kept", m_evt_tdata, 64'hBEEF_0007);
        chk("runrst_stall_clr", stall_count_o, 0);
        m_evt_tready = 1'b1;
        wait_frames(base + 8, "ev7_finish_timeout");
        send(64'hC0DE, ok);
        wait_frames(base + 9, "post_runrst_timeout");

        // Timestamp wrap across three consecutive captures.
        tick();
        force dut.ts_q = 48'hFFFF_FFFF_FFFE;
        mts = 48'hFFFF_FFFF_FFFE;
        #1 release dut.ts_q;
        base = frames_done;
        send(64'h1111, ok);
        send(64'h2222, ok);
        send(64'h3333, ok);
        wait_frames(base + 3, "wrap_frames_timeout");

        // Randomized traffic against random output back-pressure.
        base = frames_done;
        fork
            begin
                for (int k = 0; k < 1000; k++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    send({$urandom, $urandom}, ok);
                end
            end
            begin
                for (int c = 0; c < 20000 && frames_done < base + 1000; c++) begin
                    m_evt_tready = 1'($urandom_range(0, 1));
                    tick();
                end
                m_evt_tready = 1'b1;
            end
        join
        wait_frames(base + 1000, "random_frames_timeout");
        chk("random_stall_cnt", stall_count_o, mstall);

        // System reset while the first beat is stalled abandons the frame.
        m_evt_tready = 1'b0;
        send(64'hDEAD, ok);
        wait_valid("rst_frame_valid_timeout");
        sysclk_rst_i = 1'b1;
        tick();
        chk("midrst_valid", m_evt_tvalid, 0);
        chk("midrst_tlast", m_evt_tlast, 0);
        chk("midrst_tdata", m_evt_tdata, 0);
        chk("midrst_s_tready", s_hdr_tready, 0);
        sysclk_rst_i = 1'b0;
        m_evt_tready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("midrst_fifo_empty", m_evt_tvalid, 0);
        end
        base = frames_done;
        send(64'hF00D, ok);
        wait_frames(base + 1, "post_midrst_timeout");

        repeat (5) tick();
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
